// File: rtl/gearbox_tx.sv
// Transmit gearbox: packs IN_W-bit blocks MSB-first into a continuous OUT_W-bit word stream.
// Optional underrun counter enabled by defining GEARBOX_TX_UNDERRUN_CNT_EN.
module gearbox_tx #(
  parameter int unsigned IN_W  = 67,
  parameter int unsigned OUT_W = 20
) (
  input  logic             USER_CLK,
  input  logic             RESET_N,
  input  logic [IN_W-1:0]  DATA_IN,
  input  logic             DATA_IN_VALID,
  output logic             DATA_IN_RDY,
  output logic [OUT_W-1:0] DATA_OUT,
  output logic             DATA_OUT_VALID,
  output logic [15:0]      UNDERRUN_CNT
);

  localparam int unsigned BUF_W = IN_W + OUT_W - 1;
  localparam logic [6:0]  InW   = 7'(IN_W);
  localparam logic [6:0]  OutW  = 7'(OUT_W);

  logic [BUF_W-1:0] bits_q, bits_d, shifted, ins;
  logic [6:0]       cnt_q, cnt_d, rem;
  logic [OUT_W-1:0] data_out_q;
  logic             data_out_valid_q;
  logic             emit, rdy, acc;

  always_comb begin
    emit = (cnt_q >= OutW);
    rem  = emit ? (cnt_q - OutW) : cnt_q;
    rdy  = (rem < OutW);
  end

  assign DATA_IN_RDY = rdy & RESET_N;
  assign acc         = DATA_IN_VALID & rdy;

  // Unused low buffer bits stay zero, so a new block can simply be OR-ed in behind rem bits.
  always_comb begin
    shifted = emit ? (bits_q << OUT_W) : bits_q;
    ins     = {DATA_IN, {(BUF_W-IN_W){1'b0}}} >> rem;
    bits_d  = acc ? (shifted | ins) : shifted;
    cnt_d   = rem + (acc ? InW : 7'd0);
  end

  always_ff @(posedge USER_CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      bits_q           <= '0;
      cnt_q            <= '0;
      data_out_q       <= '0;
      data_out_valid_q <= 1'b0;
    end else begin
      bits_q <= bits_d;
      cnt_q  <= cnt_d;
      if (emit) begin
        data_out_q       <= bits_q[BUF_W-1 -: OUT_W];
        data_out_valid_q <= 1'b1;
      end else begin
        data_out_q       <= '0;
        data_out_valid_q <= 1'b0;
      end
    end
  end

  assign DATA_OUT       = data_out_q;
  assign DATA_OUT_VALID = data_out_valid_q;

`ifdef GEARBOX_TX_UNDERRUN_CNT_EN
  logic        started_q;
  logic [15:0] underrun_q;

  // Idle cycles before the first emitted word are start-up, not underrun.
  always_ff @(posedge USER_CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      started_q  <= 1'b0;
      underrun_q <= '0;
    end else if (emit) begin
      started_q <= 1'b1;
    end else if (started_q && (underrun_q != 16'hFFFF)) begin
      underrun_q <= underrun_q + 16'd1;
    end
  end

  assign UNDERRUN_CNT = underrun_q;
`else
  assign UNDERRUN_CNT = 16'h0000;
`endif

endmodule
